// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: datapath width, NOP encoding, PC step and
// the IF/ID boundary bundle.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] PC_INC       = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            valid;
    } ifid_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register that catches the in-flight fetch response while
// decode is stalled. Clear has priority over load.
module if_skid_buf
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= NOP_INST;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, and registers {pc, inst, valid} into IF/ID with stall and redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RST_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            id_valid,
    output logic            misaligned
);

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_pending;
    logic [XLEN-1:0] r_req_pc;
    ifid_t           r_id;
    logic            r_misaligned;

    logic            w_issue;
    logic            w_skid_load;
    logic            w_skid_clear;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_pc;
    logic [XLEN-1:0] w_skid_inst;
    ifid_t           w_id_next;

    // A new request is only safe while there is somewhere to put its response.
    assign w_issue      = !redirect && !(stall && (r_pending || w_skid_valid));
    assign w_skid_load  = !redirect && stall && r_pending;
    assign w_skid_clear = redirect || (!stall && w_skid_valid);

    assign imem_en   = w_issue;
    assign imem_addr = r_fetch_pc;

    if_skid_buf #(
        .NOP_INST (NOP_INST)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (r_req_pc),
        .i_inst  (imem_rdata),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst)
    );

    // NOTE: hold-by-default before any branch keeps this block free of latches.
    always_comb begin
        w_id_next = r_id;
        if (redirect) begin
            w_id_next.valid = 1'b0;
            w_id_next.inst  = NOP_INST;
        end else if (!stall) begin
            if (w_skid_valid) begin
                w_id_next = '{pc: w_skid_pc, inst: w_skid_inst, valid: 1'b1};
            end else if (r_pending) begin
                w_id_next = '{pc: r_req_pc, inst: imem_rdata, valid: 1'b1};
            end else begin
                w_id_next.valid = 1'b0;
                w_id_next.inst  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc   <= RST_PC;
            r_pending    <= 1'b0;
            r_req_pc     <= '0;
            r_id         <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
            r_misaligned <= 1'b0;
        end else begin
            if (redirect) begin
                r_fetch_pc <= align_word(redirect_pc);
                r_pending  <= 1'b0;
            end else if (w_issue) begin
                r_req_pc   <= r_fetch_pc;
                r_pending  <= 1'b1;
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end else begin
                r_pending  <= 1'b0;
            end
            r_id         <= w_id_next;
            r_misaligned <= redirect && (|redirect_pc[1:0]);
        end
    end

    assign id_pc      = r_id.pc;
    assign id_inst    = r_id.inst;
    assign id_valid   = r_id.valid;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: per-cycle vector table plus an in-order scoreboard
// of instructions expected to be accepted by decode.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        misaligned;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_valid    (id_valid),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        en;
        logic [31:0] addr;
        logic        idv;
        logic [31:0] idpc;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mem_xor = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mem_xor;
    endfunction

    // Synchronous-read instruction memory, 1-cycle latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    // Decode must never see a pending response and a full skid under stall.
    always @(negedge clk) begin
        if (rst && stall && dut.r_pending && dut.w_skid_valid) begin
            n_fail++;
            $display("FAIL skid_overflow: pending=1 skid_valid=1 under stall at %0t", $time);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic s, input logic r, input logic [31:0] rpc,
                       input logic en, input logic [31:0] addr,
                       input logic idv, input logic [31:0] idpc, input logic mis);
        vec_t v;
        v = '{stall: s, redir: r, rpc: rpc, en: en, addr: addr, idv: idv, idpc: idpc, mis: mis};
        vecs.push_back(v);
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        sb_t e;
        e = '{pc: pc, inst: mem_word(pc)};
        sb.push_back(e);
    endtask

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);
            check($sformatf("%s c%0d imem_en", tag, i), 32'(imem_en), 32'(vecs[i].en));
            check($sformatf("%s c%0d imem_addr", tag, i), imem_addr, vecs[i].addr);
            check($sformatf("%s c%0d id_valid", tag, i), 32'(id_valid), 32'(vecs[i].idv));
            if (vecs[i].idv) begin
                check($sformatf("%s c%0d id_pc", tag, i), id_pc, vecs[i].idpc);
                check($sformatf("%s c%0d id_inst", tag, i), id_inst, mem_word(vecs[i].idpc));
            end else begin
                check($sformatf("%s c%0d id_inst_nop", tag, i), id_inst, NOP);
            end
            check($sformatf("%s c%0d misaligned", tag, i), 32'(misaligned), 32'(vecs[i].mis));
            if (id_valid && !stall) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s c%0d sb_extra: got pc %h expected no delivery", tag, i, id_pc);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check($sformatf("%s c%0d sb_pc", tag, i), id_pc, e.pc);
                    check($sformatf("%s c%0d sb_inst", tag, i), id_inst, e.inst);
                end
            end
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    initial begin
        // Reset state while rst is held low.
        @(negedge clk);
        check("rst imem_addr", imem_addr, 32'h0);
        check("rst id_valid", 32'(id_valid), 32'd0);
        check("rst id_pc", id_pc, 32'h0);
        check("rst id_inst", id_inst, NOP);
        check("rst misaligned", 32'(misaligned), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Phase 1: memory returns the address as data.
        mem_xor = 32'h0;
        //    stall redir rpc            en  addr           idv idpc           mis
        row(0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          0); // c0
        row(0, 0, 32'h0,          1, 32'h0000_0004, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0000_0000, 0);
        row(0, 0, 32'h0,          1, 32'h0000_000C, 1, 32'h0000_0004, 0);
        row(1, 0, 32'h0,          0, 32'h0000_0010, 1, 32'h0000_0008, 0); // c4 stall
        row(1, 0, 32'h0,          0, 32'h0000_0010, 1, 32'h0000_0008, 0);
        row(1, 0, 32'h0,          0, 32'h0000_0010, 1, 32'h0000_0008, 0);
        row(0, 0, 32'h0,          1, 32'h0000_0010, 1, 32'h0000_0008, 0); // c7 release
        row(0, 0, 32'h0,          1, 32'h0000_0014, 1, 32'h0000_000C, 0);
        row(0, 0, 32'h0,          1, 32'h0000_0018, 1, 32'h0000_0010, 0);
        row(0, 0, 32'h0,          1, 32'h0000_001C, 1, 32'h0000_0014, 0);
        row(0, 0, 32'h0,          1, 32'h0000_0020, 1, 32'h0000_0018, 0);
        row(0, 1, 32'h0000_0100,  0, 32'h0000_0024, 1, 32'h0000_001C, 0); // c12 redirect
        row(0, 0, 32'h0,          1, 32'h0000_0100, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0104, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0108, 1, 32'h0000_0100, 0);
        row(0, 0, 32'h0,          1, 32'h0000_010C, 1, 32'h0000_0104, 0);
        row(0, 1, 32'h0000_0102,  0, 32'h0000_0110, 1, 32'h0000_0108, 0); // c17 misaligned
        row(0, 0, 32'h0,          1, 32'h0000_0100, 0, 32'h0,          1);
        row(0, 0, 32'h0,          1, 32'h0000_0104, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0108, 1, 32'h0000_0100, 0);
        row(1, 0, 32'h0,          0, 32'h0000_010C, 1, 32'h0000_0104, 0); // c21 stall
        row(1, 0, 32'h0,          0, 32'h0000_010C, 1, 32'h0000_0104, 0);
        row(1, 1, 32'h0000_0200,  0, 32'h0000_010C, 1, 32'h0000_0104, 0); // c23 stall+redirect
        row(0, 0, 32'h0,          1, 32'h0000_0200, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0204, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0208, 1, 32'h0000_0200, 0);
        row(0, 1, 32'hFFFF_FFFC,  0, 32'h0000_020C, 1, 32'h0000_0204, 0); // c27 wrap target
        row(0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          0);
        row(0, 0, 32'h0,          1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 0);
        row(0, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h0000_0000, 0);
        row(1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h0000_0004, 0); // c32 fill skid
        row(1, 0, 32'h0,          0, 32'h0000_000C, 1, 32'h0000_0004, 0);

        expect_pc(32'h0000_0000); expect_pc(32'h0000_0004); expect_pc(32'h0000_0008);
        expect_pc(32'h0000_000C); expect_pc(32'h0000_0010); expect_pc(32'h0000_0014);
        expect_pc(32'h0000_0018); expect_pc(32'h0000_001C); expect_pc(32'h0000_0100);
        expect_pc(32'h0000_0104); expect_pc(32'h0000_0108); expect_pc(32'h0000_0100);
        expect_pc(32'h0000_0200); expect_pc(32'h0000_0204); expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        run_vectors("p1");

        // Asynchronous reset mid-stream with the skid entry full and stall held.
        #2 rst = 1'b0;
        #1;
        check("mid_rst imem_addr", imem_addr, 32'h0);
        check("mid_rst imem_en", 32'(imem_en), 32'd1);
        check("mid_rst id_valid", 32'(id_valid), 32'd0);
        check("mid_rst id_pc", id_pc, 32'h0);
        check("mid_rst id_inst", id_inst, NOP);
        check("mid_rst misaligned", 32'(misaligned), 32'd0);
        check("mid_rst skid_valid", 32'(dut.w_skid_valid), 32'd0);
        stall   = 1'b0;
        mem_xor = 32'hA5A5_0000;
        @(posedge clk);
        #1 rst = 1'b1;

        // Phase 2: restart from RST_PC with a distinct data pattern.
        row(0, 0, 32'h0, 1, 32'h0000_0000, 0, 32'h0,          0);
        row(0, 0, 32'h0, 1, 32'h0000_0004, 0, 32'h0,          0);
        row(0, 0, 32'h0, 1, 32'h0000_0008, 1, 32'h0000_0000, 0);
        row(0, 0, 32'h0, 1, 32'h0000_000C, 1, 32'h0000_0004, 0);
        expect_pc(32'h0000_0000);
        expect_pc(32'h0000_0004);
        run_vectors("p2");

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
